// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and MEM.
// Ports:
//   clk/rst : clock, async active-high reset
//   if_*    : fetch request in; rdata/valid pulse out
//   dm_*    : load/store request in; rdata/valid pulse out
//   mem_*   : registered req/ack memory bus
//   stall_* : comb stalls; bus_err : timeout pulse
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_pipe,
   output logic              stall_fetch,
   output logic              bus_err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              dm_valid_q, dm_valid_d;
   logic              bus_err_q, bus_err_d;

   // The valid guards stop a request still held during its own
   // completion cycle from being issued a second time.
   logic dm_pend, if_pend, expire;
   assign dm_pend = dm_req & ~dm_valid_q;
   assign if_pend = if_req & ~if_valid_q;
   assign expire  = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_valid_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_valid_q  <= dm_valid_d;
         bus_err_q   <= bus_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (dm_pend)      state_d = DATA;
            else if (if_pend) state_d = FETCH;
         end
         DATA, FETCH: begin
            if (mem_ack || expire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      if_valid_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_valid_d  = 1'b0;
      bus_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_req_d = 1'b0;
            if (dm_pend) begin
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               cnt_d       = '0;
            end else if (if_pend) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
               cnt_d      = '0;
            end
         end
         DATA: begin
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               dm_valid_d = 1'b1;
               if (!mem_we_q) dm_rdata_d = mem_rdata;
            end else if (expire) begin
               mem_req_d  = 1'b0;
               dm_valid_d = 1'b1;
               bus_err_d  = 1'b1;
               if (!mem_we_q) dm_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FETCH: begin
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               if_valid_d = 1'b1;
               if_rdata_d = mem_rdata;
            end else if (expire) begin
               mem_req_d  = 1'b0;
               if_valid_d = 1'b1;
               bus_err_d  = 1'b1;
               if_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: mem_req_d = 1'b0;
      endcase
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign if_valid    = if_valid_q;
   assign dm_rdata    = dm_rdata_q;
   assign dm_valid    = dm_valid_q;
   assign bus_err     = bus_err_q;
   assign stall_pipe  = dm_pend;
   assign stall_fetch = if_pend | dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_pipe;
   logic        stall_fetch;
   logic        bus_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_valid   (if_valid),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata),
      .dm_valid   (dm_valid),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .stall_pipe (stall_pipe),
      .stall_fetch(stall_fetch),
      .bus_err    (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      if_req = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      tick(); tick();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // 1: reset in the middle of a data access
      dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'h5;
      tick();
      chk("t1_req", {31'd0, mem_req}, 32'd1);
      chk("t1_addr", mem_addr, 32'h300);
      rst = 1'b1;
      #1;
      chk("t1_async_req", {31'd0, mem_req}, 32'd0);
      chk("t1_async_addr", mem_addr, 32'd0);
      chk("t1_async_we", {31'd0, mem_we}, 32'd0);
      chk("t1_async_wd", mem_wdata, 32'd0);
      chk("t1_stall", {31'd0, stall_pipe}, 32'd1);
      dm_req = 0;
      tick();
      rst = 1'b0;
      tick();
      chk("t1_idle", {31'd0, mem_req}, 32'd0);

      // mem_ack while idle is ignored
      mem_ack = 1; mem_rdata = 32'hFFFF0000;
      tick();
      mem_ack = 0;
      chk("idle_ack_dv", {31'd0, dm_valid}, 32'd0);
      chk("idle_ack_iv", {31'd0, if_valid}, 32'd0);
      chk("idle_ack_rd", dm_rdata, 32'd0);

      // 2: load, ack three cycles after mem_req rises
      dm_req = 1; dm_we = 0; dm_addr = 32'h100;
      #1;
      chk("t2_stall0", {31'd0, stall_pipe}, 32'd1);
      chk("t2_sf0", {31'd0, stall_fetch}, 32'd1);
      tick();
      chk("t2_req", {31'd0, mem_req}, 32'd1);
      chk("t2_addr", mem_addr, 32'h100);
      chk("t2_we", {31'd0, mem_we}, 32'd0);
      tick();
      chk("t2_req2", {31'd0, mem_req}, 32'd1);
      chk("t2_stall2", {31'd0, stall_pipe}, 32'd1);
      tick();
      chk("t2_dv3", {31'd0, dm_valid}, 32'd0);
      tick();
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 0; mem_rdata = 0;
      chk("t2_dv", {31'd0, dm_valid}, 32'd1);
      chk("t2_rd", dm_rdata, 32'hDEADBEEF);
      chk("t2_req_off", {31'd0, mem_req}, 32'd0);
      chk("t2_stall_off", {31'd0, stall_pipe}, 32'd0);
      dm_req = 0;
      tick();
      chk("t2_dv_pulse", {31'd0, dm_valid}, 32'd0);
      chk("t2_rd_hold", dm_rdata, 32'hDEADBEEF);

      // 3: both pending, data first
      if_req = 1; if_addr = 32'h40;
      dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
      tick();
      chk("t3_we", {31'd0, mem_we}, 32'd1);
      chk("t3_addr", mem_addr, 32'h2000);
      chk("t3_wd", mem_wdata, 32'h12345678);
      mem_ack = 1; mem_rdata = 32'h99999999;
      tick();
      mem_ack = 0;
      chk("t3_dv", {31'd0, dm_valid}, 32'd1);
      chk("t3_iv0", {31'd0, if_valid}, 32'd0);
      chk("t3_st_rd", dm_rdata, 32'hDEADBEEF);
      dm_req = 0; dm_we = 0;
      tick();
      chk("t3_f_req", {31'd0, mem_req}, 32'd1);
      chk("t3_f_addr", mem_addr, 32'h40);
      chk("t3_f_we", {31'd0, mem_we}, 32'd0);
      chk("t3_sf", {31'd0, stall_fetch}, 32'd1);
      mem_ack = 1; mem_rdata = 32'h00000013;
      tick();
      mem_ack = 0;
      chk("t3_iv", {31'd0, if_valid}, 32'd1);
      chk("t3_ird", if_rdata, 32'h13);
      chk("t3_dv0", {31'd0, dm_valid}, 32'd0);
      chk("t3_sf_off", {31'd0, stall_fetch}, 32'd0);
      if_req = 0;
      tick();
      chk("t3_iv_pulse", {31'd0, if_valid}, 32'd0);
      chk("t3_idle", {31'd0, mem_req}, 32'd0);

      // 4: data request arrives during a fetch
      if_req = 1; if_addr = 32'h80;
      tick();
      chk("t4_f_addr", mem_addr, 32'h80);
      dm_req = 1; dm_we = 0; dm_addr = 32'h400;
      #1;
      chk("t4_stall_a", {31'd0, stall_pipe}, 32'd1);
      tick();
      chk("t4_hold_addr", mem_addr, 32'h80);
      chk("t4_stall_b", {31'd0, stall_pipe}, 32'd1);
      mem_ack = 1; mem_rdata = 32'hAAAA5555;
      tick();
      mem_ack = 0;
      chk("t4_iv", {31'd0, if_valid}, 32'd1);
      chk("t4_ird", if_rdata, 32'hAAAA5555);
      chk("t4_dv0", {31'd0, dm_valid}, 32'd0);
      chk("t4_stall_c", {31'd0, stall_pipe}, 32'd1);
      if_req = 0;
      tick();
      chk("t4_d_req", {31'd0, mem_req}, 32'd1);
      chk("t4_d_addr", mem_addr, 32'h400);
      chk("t4_stall_d", {31'd0, stall_pipe}, 32'd1);
      mem_ack = 1; mem_rdata = 32'h11112222;
      tick();
      mem_ack = 0;
      chk("t4_dv", {31'd0, dm_valid}, 32'd1);
      chk("t4_drd", dm_rdata, 32'h11112222);
      chk("t4_stall_off", {31'd0, stall_pipe}, 32'd0);
      dm_req = 0;
      tick();

      // 5a: timeout with no ack
      dm_req = 1; dm_we = 0; dm_addr = 32'h500;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t5_req%0d", i), {31'd0, mem_req}, 32'd1);
         chk($sformatf("t5_err%0d", i), {31'd0, bus_err}, 32'd0);
      end
      tick();
      chk("t5_req_off", {31'd0, mem_req}, 32'd0);
      chk("t5_err", {31'd0, bus_err}, 32'd1);
      chk("t5_dv", {31'd0, dm_valid}, 32'd1);
      chk("t5_rd", dm_rdata, 32'd0);
      dm_req = 0;
      tick();
      chk("t5_err_pulse", {31'd0, bus_err}, 32'd0);
      chk("t5_dv_pulse", {31'd0, dm_valid}, 32'd0);

      // 5b: ack on the last allowed cycle wins
      dm_req = 1; dm_we = 0; dm_addr = 32'h600;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5b_req%0d", i), {31'd0, mem_req}, 32'd1);
      end
      tick();
      chk("t5b_req3", {31'd0, mem_req}, 32'd1);
      mem_ack = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 0;
      chk("t5b_err", {31'd0, bus_err}, 32'd0);
      chk("t5b_dv", {31'd0, dm_valid}, 32'd1);
      chk("t5b_rd", dm_rdata, 32'hCAFEF00D);
      dm_req = 0;
      tick();

      // 6: request held through its valid cycle, then a new one
      dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h77;
      tick();
      chk("t6_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      chk("t6_dv", {31'd0, dm_valid}, 32'd1);
      tick();
      chk("t6_no_reissue", {31'd0, mem_req}, 32'd0);
      chk("t6_dv_pulse", {31'd0, dm_valid}, 32'd0);
      chk("t6_st_rd", dm_rdata, 32'hCAFEF00D);
      dm_addr = 32'h704; dm_wdata = 32'h88;
      tick();
      chk("t6_new_req", {31'd0, mem_req}, 32'd1);
      chk("t6_new_addr", mem_addr, 32'h704);
      chk("t6_new_wd", mem_wdata, 32'h88);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      chk("t6_new_dv", {31'd0, dm_valid}, 32'd1);
      dm_req = 0;
      tick();
      chk("t6_end_idle", {31'd0, mem_req}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
